// File: rtl/ring_router_demux_if.sv
// rtl/ring_router_demux_if.sv - dii_channel flit stream: 16-bit data, last, valid/ready handshake
interface ring_router_demux_if;
  logic [15:0] data;
  logic        last;
  logic        valid;
  logic        ready;

  modport master (output data, output last, output valid, input ready);
  modport slave  (input data, input last, input valid, output ready);
endinterface

// File: rtl/ring_router_demux.sv
// rtl/ring_router_demux.sv - ring router ingress demux, routes worms to local or ring output by header dest
// Optional output register stage enabled by defining RING_ROUTER_DEMUX_OUTREG_EN.
module ring_router_demux (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [9:0]                 id,
  ring_router_demux_if.slave         in,
  ring_router_demux_if.master        out_local,
  ring_router_demux_if.master        out_ring
);

  typedef enum logic [1:0] {IDLE, WORM_LOCAL, WORM_RING} state_e;

  state_e state_q, state_d;
  logic   hdr_local;
  logic   sel_local;
  logic   in_xfer;

  // Only a header flit (IDLE) is decoded; inside a worm the route is held.
  always_comb begin
    hdr_local = (in.data[9:0] == id);
    sel_local = (state_q == IDLE) ? hdr_local : (state_q == WORM_LOCAL);
  end

  assign in_xfer = in.valid & in.ready;

`ifdef RING_ROUTER_DEMUX_OUTREG_EN
  logic        reg_valid_q, reg_valid_d;
  logic        reg_last_q,  reg_last_d;
  logic        reg_sel_q,   reg_sel_d;
  logic [15:0] reg_data_q,  reg_data_d;
  logic        reg_out_ready;

  // A drained or draining register accepts a new flit in the same cycle.
  always_comb begin
    reg_out_ready = reg_sel_q ? out_local.ready : out_ring.ready;
    in.ready      = !rst && (!reg_valid_q || reg_out_ready);

    reg_valid_d = reg_valid_q;
    reg_last_d  = reg_last_q;
    reg_sel_d   = reg_sel_q;
    reg_data_d  = reg_data_q;
    if (in.valid && in.ready) begin
      reg_valid_d = 1'b1;
      reg_last_d  = in.last;
      reg_sel_d   = sel_local;
      reg_data_d  = in.data;
    end else if (reg_valid_q && reg_out_ready) begin
      reg_valid_d = 1'b0;
    end

    out_local.valid = reg_valid_q && reg_sel_q;
    out_local.data  = reg_data_q;
    out_local.last  = reg_last_q;
    out_ring.valid  = reg_valid_q && !reg_sel_q;
    out_ring.data   = reg_data_q;
    out_ring.last   = reg_last_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      reg_valid_q <= 1'b0;
      reg_last_q  <= 1'b0;
      reg_sel_q   <= 1'b0;
      reg_data_q  <= 16'h0000;
    end else begin
      reg_valid_q <= reg_valid_d;
      reg_last_q  <= reg_last_d;
      reg_sel_q   <= reg_sel_d;
      reg_data_q  <= reg_data_d;
    end
  end
`else
  // Pass-through: outputs are gated during rst so nothing is offered or accepted.
  always_comb begin
    in.ready        = !rst && (sel_local ? out_local.ready : out_ring.ready);
    out_local.valid = !rst && in.valid && sel_local;
    out_local.data  = in.data;
    out_local.last  = in.last;
    out_ring.valid  = !rst && in.valid && !sel_local;
    out_ring.data   = in.data;
    out_ring.last   = in.last;
  end
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (in_xfer && !in.last) begin
          state_d = hdr_local ? WORM_LOCAL : WORM_RING;
        end
      end
      WORM_LOCAL, WORM_RING: begin
        if (in_xfer && in.last) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

endmodule

// File: doc/ring_router_demux.md
# ring_router_demux

Ring-router ingress demultiplexer on the debug interconnect: splits one incoming dii_channel worm stream onto a local-delivery output and a ring-forward output. It routes on the destination field of each packet's header flit and holds the route until that packet's `last` flit has transferred. It is the companion of the 2:1 round-robin egress mux; together they form one ring router stage.

## Interface
- Parameters: none. Local ID is supplied by port so one netlist serves every ring position.
- `clk` input 1 — sole clock; all state updates on rising edge.
- `rst` input 1 — synchronous, active-high reset.
- `id` input 10 — this node's debug module ID; quasi-static, changes only during `rst`.
- `in` dii_channel (slave) — incoming flits: `data[15:0]`, `last`, `valid`, `ready` (driven by this block).
- `out_local` dii_channel (master) — packets whose destination equals `id`.
- `out_ring` dii_channel (master) — all other packets, forwarded along the ring.

## Operation
- Header flit: the first flit after reset or after a transferred `last` flit. Destination is `in.data[9:0]`.
- Route: `dest == id` → LOCAL; otherwise → RING. Only header flits are decoded; payload flits are never inspected.
- FSM states: IDLE, WORM_LOCAL, WORM_RING; reset state IDLE.
- IDLE: when `in.valid`, present the header to the selected output and drive `in.ready` from that output's `ready`.
  - If the header transfers with `last=0` → WORM_LOCAL or WORM_RING.
  - If the header transfers with `last=1` (single-flit packet) → stay in IDLE.
  - No transfer → stay in IDLE; the route is re-evaluated next cycle from the same held flit.
- WORM_x: connect `in` to output x only (`valid`, `data`, `last` forward; `ready` back).
  - Transfer with `last=1` → IDLE.
- The non-selected output always has `valid=0`.
- `data` and `last` on any output are don't-care while its `valid=0`; the bench must not check them.
- Handshake: a transfer occurs on a cycle with `valid & ready`. `valid` and `data` must not depend combinationally on the same port's `ready`. Once a flit is offered with `valid=1`, it is held stable until it transfers.
- Backpressure: a stalled selected output stalls `in`. It does not block the other output beyond the current packet.
- Reset mid-worm: FSM returns to IDLE and any registered flit is discarded. Upstream and downstream are reset in the same cycle.

## Timing
- Reset values:
  - `out_local.valid=0`, `out_ring.valid=0`, `in.ready=0`.
  - FSM = IDLE, output register empty.
  - First `in.ready=1` is possible in the cycle after `rst` deasserts.
- Without the macro: zero-cycle latency. `in`→`out_x` is purely combinational, and `in.ready` = selected `out_x.ready`.
- With the macro: one-cycle latency and full throughput (1 flit/cycle sustained).
- Throughput: a route switch costs no bubble. A header may transfer in the same cycle the FSM returns to IDLE from the previous packet's `last`, evaluated in the following cycle.

## Configuration
- `RING_ROUTER_DEMUX_OUTREG_EN` defined: one-entry output register holding flit, `last` and route select.
  - `in.ready = !reg_valid | sel_out.ready`, where `sel_out` is the register's route.
  - The register loads on an `in` transfer. `out_x.valid = reg_valid & (reg_sel==x)`.
  - The FSM advances on the `in` transfer, not the output transfer.
  - Breaks the valid/data timing path between routers; `ready` remains combinational.
- Macro undefined: combinational pass-through as described above; no flit storage.

## Test plan
- Single-flit local: `id=0x005`, in flit `data=0x0005`, `last=1` → `out_local` carries `0x0005`, `out_ring.valid` stays 0, FSM stays IDLE.
- 3-flit ring worm: `id=0x005`, header `0x0012`, payloads `0x0005`, `0xBEEF` (last) → all three on `out_ring` in order. Payload `0x0005` is not diverted to local.
- Back-to-back switch: local 2-flit packet immediately followed by ring 1-flit packet, both outputs always ready → 3 transfers in 3 consecutive cycles (+1 cycle with `OUTREG_EN`), no bubble.
- Backpressure: ring worm in progress, `out_ring.ready=0` for 4 cycles → `in.ready=0` for those cycles, output data stable, no flit lost or duplicated. `out_local.valid=0` throughout.
- Reset mid-worm: assert `rst` after the 2nd of 4 flits → all `valid=0` next cycle. A new header `0x0005` after reset routes to local.
- Random stress: random `valid`/`ready`, lengths 1–8, 50% local → per-output packet order and content match the reference model, and `last` counts match.
